// File: rtl/fp32_quant_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fp32_quant_search_ctrl
// Brief    : FP32 threshold quantizer controller; binary search over a
//            programmable ascending threshold table using one shared comparator.
// Revision : 1.0  initial release
// ============================================================================
module fp32_quant_search_ctrl #(
    parameter int LVL_BITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [LVL_BITS-1:0] cfg_addr,
    input  logic [31:0]         cfg_data,
    output logic                cfg_err,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LVL_BITS-1:0] out_level
);

    localparam int c_num_lvl = 1 << LVL_BITS;
    localparam int c_step_w  = (LVL_BITS > 1) ? $clog2(LVL_BITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [31:0]          r_thr [c_num_lvl];
    logic [31:0]          r_sample;
    logic [LVL_BITS-1:0]  r_idx;
    logic [LVL_BITS-1:0]  r_level;
    logic [c_step_w-1:0]  r_step;
    logic                 r_cfg_err;

    logic                 w_wr_ok;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_hit;
    logic [LVL_BITS-1:0]  w_cand;
    logic [LVL_BITS-1:0]  w_idx_nxt;

    // Raw-bit float ordering: sign decides first, then magnitude bits,
    // whose order flips when both operands are negative (so -0 < +0).
    function automatic logic f_ge(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31])
            return b[31];
        else if (a[31])
            return (a[30:0] <= b[30:0]);
        else
            return (a[30:0] >= b[30:0]);
    endfunction

    assign w_wr_ok   = cfg_we && (r_state == S_IDLE) && (cfg_addr != '0);
    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign w_last    = (r_step == '0);
    assign w_cand    = r_idx | (LVL_BITS'(1) << r_step);
    assign w_hit     = f_ge(r_sample, r_thr[w_cand]);
    assign w_idx_nxt = w_hit ? w_cand : r_idx;

    assign cfg_err   = r_cfg_err;
    assign out_level = r_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    w_state_nxt = S_SEARCH;
            end
            S_SEARCH: begin
                if (w_last)
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Threshold table; a write landing in the same cycle as an accept is
    // visible to that sample's first compare on the following edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_num_lvl; i++)
                r_thr[i] <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            if (w_wr_ok)
                r_thr[cfg_addr] <= cfg_data;
            r_cfg_err <= cfg_we && !w_wr_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample <= '0;
            r_idx    <= '0;
            r_step   <= '0;
            r_level  <= '0;
        end else begin
            if (w_accept) begin
                r_sample <= in_data;
                r_idx    <= '0;
                r_step   <= c_step_w'(LVL_BITS - 1);
            end else if (r_state == S_SEARCH) begin
                r_idx <= w_idx_nxt;
                if (w_last)
                    r_level <= w_idx_nxt;
                else
                    r_step <= r_step - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp32_quant_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp32_quant_search_ctrl
// Brief    : Directed bench for fp32_quant_search_ctrl with a counting model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp32_quant_search_ctrl;

    localparam int LB = 3;
    localparam int NL = 1 << LB;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [LB-1:0] cfg_addr;
    logic [31:0]   cfg_data;
    logic          cfg_err;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          out_valid;
    logic          out_ready;
    logic [LB-1:0] out_level;

    fp32_quant_search_ctrl #(.LVL_BITS(LB)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_level (out_level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0]   m_thr [NL];
    logic [31:0]   m_sample;
    logic          m_busy = 1'b0;
    logic          m_valid = 1'b0;
    logic          m_err = 1'b0;
    logic          m_live = 1'b0;
    logic [LB-1:0] m_level = '0;
    int            m_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monotonic unsigned key for raw-bit float ordering (-0 sorts below +0).
    function automatic logic [31:0] fkey(input logic [31:0] f);
        return f[31] ? ~f : (f | 32'h8000_0000);
    endfunction

    // For an ascending table the level is the number of thresholds <= sample.
    function automatic int quant(input logic [31:0] s);
        int n = 0;
        for (int k = 1; k < NL; k++)
            if (fkey(s) >= fkey(m_thr[k])) n++;
        return n;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_err   <= 1'b0;
            m_level <= '0;
            m_cnt   <= 0;
            m_live  <= 1'b1;
            for (int k = 0; k < NL; k++) m_thr[k] <= '0;
        end else begin
            m_err <= cfg_we && (m_busy || cfg_addr == '0);
            if (cfg_we && !m_busy && cfg_addr != '0)
                m_thr[cfg_addr] <= cfg_data;
            if (m_valid) begin
                if (out_ready) begin
                    m_valid <= 1'b0;
                    m_busy  <= 1'b0;
                end
            end else if (m_busy) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_valid <= 1'b1;
                    m_level <= LB'(quant(m_sample));
                end
            end else if (in_valid) begin
                m_busy   <= 1'b1;
                m_cnt    <= LB;
                m_sample <= in_data;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("in_ready",  {31'b0, in_ready},  {31'b0, !m_busy});
            check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
            check("out_level", {29'b0, out_level}, {29'b0, m_level});
            check("cfg_err",   {31'b0, cfg_err},   {31'b0, m_err});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_thr(input logic [LB-1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic start(input logic [31:0] d);
        in_valid = 1'b1; in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic finish(input int exp_lvl, input int exp_lat, input int hold);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("latency", n, exp_lat);
        check("level", {29'b0, out_level}, exp_lvl);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", {31'b0, out_valid}, 1);
            check("hold_level", {29'b0, out_level}, exp_lvl);
            check("hold_ready", {31'b0, in_ready}, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_valid", {31'b0, out_valid}, 0);
        check("post_ready", {31'b0, in_ready}, 1);
    endtask

    logic [31:0] tbl [NL];

    initial begin
        tbl = '{32'h0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000};
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_in_ready",  {31'b0, in_ready},  1);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_out_level", {29'b0, out_level}, 0);
        check("rst_cfg_err",   {31'b0, cfg_err},   0);

        for (int k = 1; k < NL; k++) write_thr(LB'(k), tbl[k]);
        tick();
        check("model_2p5",  quant(32'h4020_0000), 2);
        check("model_4p0",  quant(32'h4080_0000), 4);
        check("model_neg3", quant(32'hC040_0000), 0);

        // T1 / T2
        start(32'h4020_0000); finish(2, 3, 0);
        start(32'h4080_0000); finish(4, 3, 0);
        start(32'h42C8_0000); finish(7, 3, 0);
        start(32'hC040_0000); finish(0, 3, 0);

        // T4: 5.5 held under backpressure
        start(32'h40B0_0000); finish(5, 3, 5);

        // T5: rejected writes while busy and to address 0
        start(32'h4020_0000);
        write_thr(3, 32'h4100_0000);
        check("t5_err_busy", {31'b0, cfg_err}, 1);
        finish(2, 2, 0);
        write_thr(0, 32'h3F00_0000);
        check("t5_err_addr0", {31'b0, cfg_err}, 1);
        tick();
        check("t5_err_clear", {31'b0, cfg_err}, 0);
        start(32'h4020_0000); finish(2, 3, 0);

        // T3: signed zero ordering
        write_thr(1, 32'h0000_0000);
        start(32'h8000_0000); finish(0, 3, 0);
        start(32'h0000_0000); finish(1, 3, 0);
        write_thr(1, 32'h3F80_0000);

        // T6: reset during search
        start(32'h4020_0000);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_in_ready",  {31'b0, in_ready},  1);
        check("t6_out_valid", {31'b0, out_valid}, 0);
        check("t6_out_level", {29'b0, out_level}, 0);
        repeat (4) tick();
        check("t6_no_valid", {31'b0, out_valid}, 0);
        start(32'h3F80_0000); finish(7, 3, 0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
